// File: rtl/cmos_dvp_pattern_gen.sv
// cmos_dvp_pattern_gen: DVP sensor emulator producing vsync/href/data frames with test patterns
// Position counters track the pixel being driven; outputs are registered from the next position.
module cmos_dvp_pattern_gen #(
   parameter int RAW_WIDTH   = 10,
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 160,
   parameter int VSYNC_LINES = 2,
   parameter int V_BACK      = 16,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10
) (
   input  logic                 pixel_clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic [RAW_WIDTH-1:0] const_val,
   output logic                 vsync,
   output logic                 href,
   output logic [RAW_WIDTH-1:0] data_out,
   output logic                 frame_start,
   output logic [15:0]          frame_cnt
);
   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
   localparam logic [15:0] HT_M1 = 16'(H_ACTIVE + H_BLANK - 1);
   localparam logic [15:0] HA    = 16'(H_ACTIVE);
   localparam logic [15:0] VS_M1 = 16'(VSYNC_LINES - 1);
   localparam logic [15:0] VB_M1 = 16'(V_BACK - 1);
   localparam logic [15:0] VA_M1 = 16'(V_ACTIVE - 1);
   localparam logic [15:0] VF_M1 = 16'(V_FRONT - 1);
   state_t                 state_q, state_d, nxt;
   logic [15:0]            x_q, x_d, line_q, line_d, last_line;
   logic                   x_end, l_end, start;
   logic [1:0]             mode_q, mode_d;
   logic [RAW_WIDTH-1:0]   const_q, const_d, pix;
   logic                   vsync_q, vsync_d, href_q, href_d, frame_start_q, frame_start_d;
   logic [RAW_WIDTH-1:0]   data_q, data_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   always_comb begin
      last_line = state_q == VSYNC ? VS_M1 : state_q == VBACK ? VB_M1 : state_q == ACTIVE ? VA_M1 : VF_M1;
      x_end = x_q == HT_M1;
      l_end = line_q == last_line;
      // frame end only leaves VFRONT; en decides between back-to-back frame and idle
      nxt = state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE : state_q == ACTIVE ? VFRONT : en ? VSYNC : IDLE;
      state_d = state_q == IDLE ? (en ? VSYNC : IDLE) : (x_end && l_end) ? nxt : state_q;
      x_d = (state_q == IDLE || x_end) ? '0 : x_q + 16'd1;
      line_d = (state_q == IDLE || (x_end && l_end)) ? '0 : x_end ? line_q + 16'd1 : line_q;
      start = state_d == VSYNC && (state_q == IDLE || state_q == VFRONT);
      mode_d = start ? mode : mode_q;
      const_d = start ? const_val : const_q;
      pix = mode_q == 2'd0 ? RAW_WIDTH'(x_d) : mode_q == 2'd1 ? RAW_WIDTH'(line_d) :
            mode_q == 2'd2 ? {RAW_WIDTH{x_d[3] ^ line_d[3]}} : const_q;
      vsync_d = state_d == VSYNC;
      href_d = state_d == ACTIVE && x_d < HA;
      data_d = href_d ? pix : '0;
      frame_start_d = start;
      frame_cnt_d = frame_cnt_q + {15'd0, start};
   end
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         line_q        <= '0;
         mode_q        <= '0;
         const_q       <= '0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         data_q        <= '0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         line_q        <= line_d;
         mode_q        <= mode_d;
         const_q       <= const_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         data_q        <= data_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end
   assign vsync       = vsync_q;
   assign href        = href_q;
   assign data_out    = data_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// tb_cmos_dvp_pattern_gen: random stimulus against a frame-cycle-index reference model
module tb_cmos_dvp_pattern_gen;
   localparam int RW = 10, HA = 8, HB = 4, VS = 1, VB = 1, VA = 4, VF = 1;
   localparam int HT = HA + HB;
   localparam int FT = (VS + VB + VA + VF) * HT;
   logic          clk, rst, en;
   logic [1:0]    mode;
   logic [RW-1:0] const_val;
   logic          vsync, href, frame_start;
   logic [RW-1:0] data_out;
   logic [15:0]   frame_cnt;
   int            checks = 0, errors = 0;
   bit            run = 0, fs = 0, clean = 0, vs_prev = 0, href_prev = 0;
   int            t = 0, m_mode = 0, m_const = 0, cnt = 0, lines = 0;
   cmos_dvp_pattern_gen #(.RAW_WIDTH(RW), .H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
      .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)) dut (
      .pixel_clk(clk), .rst(rst), .en(en), .mode(mode), .const_val(const_val),
      .vsync(vsync), .href(href), .data_out(data_out), .frame_start(frame_start), .frame_cnt(frame_cnt));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // one clock: advance the model with the inputs seen at the edge, then compare at the falling edge
   task automatic step();
      int ln, x, a, e_data;
      bit e_vs, e_href;
      @(posedge clk);
      fs = 0;
      if (rst) begin
         run = 0; t = 0; cnt = 0; clean = 0;
      end else if (!run || t == FT - 1) begin
         if (en) begin
            run = 1; t = 0; m_mode = int'(mode); m_const = int'(const_val);
            cnt = (cnt + 1) % 65536; fs = 1;
         end else begin
            run = 0; t = 0;
         end
      end else t++;
      @(negedge clk);
      ln = t / HT; x = t % HT; a = ln - VS - VB;
      e_vs = run && ln < VS;
      e_href = run && a >= 0 && a < VA && x < HA;
      e_data = !e_href ? 0 : m_mode == 0 ? x % 1024 : m_mode == 1 ? a % 1024 :
               m_mode == 2 ? ((((x >> 3) ^ (a >> 3)) & 1) != 0 ? 1023 : 0) : m_const;
      check("vsync", 32'(vsync), 32'(e_vs));
      check("href", 32'(href), 32'(e_href));
      check("data", 32'(data_out), 32'(e_data));
      check("frame_start", 32'(frame_start), 32'(fs));
      check("frame_cnt", 32'(frame_cnt), 32'(cnt));
      if (href_prev && !href) lines++;
      if (vsync && !vs_prev) begin
         if (clean) check("capture_lines", 32'(lines), 32'(VA));
         clean = 1; lines = 0;
      end
      href_prev = href; vs_prev = vsync;
   endtask
   initial begin
      int n;
      rst = 1; en = 0; mode = 0; const_val = 0;
      repeat (3) step();
      rst = 0;
      repeat (100) step();
      en = 1;
      repeat (200) step();
      mode = 1;
      repeat (170) step();
      mode = 2;
      repeat (170) step();
      mode = 3; const_val = 10'h155;
      repeat (90) step();
      repeat (170) begin
         mode = 2'($urandom_range(0, 3)); const_val = RW'($urandom);
         step();
      end
      n = 0;
      while (!(run && t / HT - VS - VB == 2) && n < 500) begin step(); n++; end
      check("reach_line2", 32'(n < 500), 32'd1);
      en = 0;
      repeat (200) step();
      en = 1;
      n = 0;
      while (!(run && t / HT - VS - VB == 1) && n < 500) begin step(); n++; end
      check("reach_active", 32'(n < 500), 32'd1);
      rst = 1;
      step();
      rst = 0;
      repeat (200) step();
      repeat (3000) begin
         rst = $urandom_range(0, 199) == 0;
         en = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 19) == 0) begin
            mode = 2'($urandom_range(0, 3)); const_val = RW'($urandom);
         end
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
